// File: rtl/seven_seg_if.sv
// Segment-decoder bus: raw segment input, ready/valid result handshake and
// status flags. err_cnt exists only when SEVEN_SEG_DECODER_ERRCNT_EN is defined.
interface seven_seg_if;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] digit;
  logic       err;
  logic       overrun;
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  // Producer of segment patterns / consumer of decoded results.
  modport master (
    output seg_in,
    output out_ready,
    input  out_valid,
    input  digit,
    input  err,
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
    input  err_cnt,
`endif
    input  overrun
  );

  // The decoder itself.
  modport slave (
    input  seg_in,
    input  out_ready,
    output out_valid,
    output digit,
    output err,
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
    output err_cnt,
`endif
    output overrun
  );
endinterface

// File: rtl/seven_seg_decoder.sv
// Seven-segment pattern decoder with input debouncing.
// A new pattern must be seen STABLE_CYCLES consecutive times before it is
// decoded and offered on a ready/valid handshake; the result is held until
// accepted. Optional macro SEVEN_SEG_DECODER_ERRCNT_EN adds a saturating
// count of accepted unrecognised patterns (err_cnt).
module seven_seg_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input logic         clk,
  input logic         rst,
  seven_seg_if.slave  bus
);

  localparam logic [6:0] PAT_ZERO = 7'b0111111;
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] cand, cand_nxt;
  logic [6:0] last_pat;
  logic [7:0] cnt, cnt_nxt;
  logic       accept;
  logic [3:0] digit_hold;
  logic       err_hold;
  logic       overrun_flag;
  logic       handshake;
  logic [4:0] dec;

  // Returns {err, digit} for a segment pattern (bit0=a .. bit6=g).
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'b0111111: r = {1'b0, 4'h0};
      7'b0000110: r = {1'b0, 4'h1};
      7'b1011011: r = {1'b0, 4'h2};
      7'b1001111: r = {1'b0, 4'h3};
      7'b1100110: r = {1'b0, 4'h4};
      7'b1101101: r = {1'b0, 4'h5};
      7'b1111100: r = {1'b0, 4'h6};
      7'b0000111: r = {1'b0, 4'h7};
      7'b1111111: r = {1'b0, 4'h8};
      7'b1100111: r = {1'b0, 4'h9};
      7'b0000000: r = {1'b0, 4'hA};
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  assign handshake = (state == EMIT) && bus.out_ready;
  assign dec       = decode(bus.seg_in);

  // Next-state logic: track a candidate pattern until it has been stable long enough.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.seg_in != last_pat) begin
          cand_nxt = bus.seg_in;
          cnt_nxt  = 8'd1;
          if (STABLE_CYCLES == 1) begin
            accept    = 1'b1;
            state_nxt = EMIT;
          end else begin
            state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (bus.seg_in == last_pat) begin
          // Input fell back to the already reported pattern: nothing new.
          state_nxt = IDLE;
        end else if (bus.seg_in != cand) begin
          cand_nxt = bus.seg_in;
          cnt_nxt  = 8'd1;
        end else if (cnt == CNT_LAST) begin
          accept    = 1'b1;
          state_nxt = EMIT;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      EMIT: begin
        // Input is not tracked while a result is held; IDLE re-compares later.
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, candidate tracking and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= PAT_ZERO;
      cnt        <= 8'd0;
      last_pat   <= PAT_ZERO;
      digit_hold <= 4'h0;
      err_hold   <= 1'b0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        last_pat   <= bus.seg_in;
        digit_hold <= dec[3:0];
        err_hold   <= dec[4];
      end
    end
  end

  // Sticky flag: input moved while a result sat unaccepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_flag <= 1'b0;
    end else if ((state == EMIT) && (bus.seg_in != last_pat) && !bus.out_ready) begin
      overrun_flag <= 1'b1;
    end
  end

`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
  logic [7:0] err_total;

  // Count accepted error results, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_total <= 8'd0;
    end else if (handshake && err_hold && (err_total != 8'hFF)) begin
      err_total <= err_total + 8'd1;
    end
  end

  assign bus.err_cnt = err_total;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

  assign bus.out_valid = (state == EMIT);
  assign bus.digit     = digit_hold;
  assign bus.err       = err_hold;
  assign bus.overrun   = overrun_flag;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed bench for seven_seg_decoder: a STABLE_CYCLES=4 instance runs the
// debounce/handshake scenarios, a STABLE_CYCLES=1 instance sweeps the digit table.
module tb_seven_seg_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seven_seg_if bus();
  seven_seg_if bus1();

  seven_seg_decoder #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seven_seg_decoder #(.STABLE_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold pat for n cycles; out_valid must be high only on tick 'at' (0 = never),
  // where digit/err must match.
  task automatic run_seg(input string tag, input logic [6:0] pat, input int n,
                         input int at, input logic [3:0] exp_d, input logic exp_e);
    bus.seg_in = pat;
    for (int i = 1; i <= n; i++) begin
      tick();
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(i == at));
      if (i == at) begin
        chk({tag, "_digit"}, 32'(bus.digit), 32'(exp_d));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_e));
      end
    end
  endtask

  logic [6:0] pats [10];
  initial begin
    pats[0] = 7'b0111111; pats[1] = 7'b0000110; pats[2] = 7'b1011011;
    pats[3] = 7'b1001111; pats[4] = 7'b1100110; pats[5] = 7'b1101101;
    pats[6] = 7'b1111100; pats[7] = 7'b0000111; pats[8] = 7'b1111111;
    pats[9] = 7'b1100111;
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.seg_in = 7'b0111111;
    bus.out_ready = 1'b1;
    bus1.seg_in = 7'b0111111;
    bus1.out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_digit", 32'(bus.digit), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
    chk("rst_errcnt", 32'(bus.err_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Steady zero pattern after reset: nothing to report
    run_seg("steady0", 7'b0111111, 8, 0, 4'h0, 1'b0);

    // Change to 6: valid on the 4th edge after the change, one cycle only
    run_seg("six", 7'b1111100, 6, 4, 4'h6, 1'b0);

    // 1 for only two cycles, then 2 held: only 2 is reported
    run_seg("one_short", 7'b0000110, 2, 0, 4'h1, 1'b0);
    run_seg("two", 7'b1011011, 7, 4, 4'h2, 1'b0);

    // Unrecognised pattern
    run_seg("bad", 7'b1010101, 6, 4, 4'hF, 1'b1);
`ifdef SEVEN_SEG_DECODER_ERRCNT_EN
    chk("errcnt_after_bad", 32'(bus.err_cnt), 32'd1);
`endif

    // Blank, then a one-cycle glitch of 9 that must be ignored
    run_seg("blank", 7'b0000000, 6, 4, 4'hA, 1'b0);
    run_seg("glitch9", 7'b1100111, 1, 0, 4'h9, 1'b0);
    run_seg("blank_hold", 7'b0000000, 8, 0, 4'hA, 1'b0);

    // Backpressure: 5 held, input moves to 7 -> overrun, 5 still held
    bus.out_ready = 1'b0;
    run_seg("five", 7'b1101101, 4, 4, 4'h5, 1'b0);
    chk("five_overrun_before", 32'(bus.overrun), 32'd0);
    bus.seg_in = 7'b0000111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("five_held_valid", 32'(bus.out_valid), 32'd1);
      chk("five_held_digit", 32'(bus.digit), 32'd5);
    end
    chk("overrun_set", 32'(bus.overrun), 32'd1);
    bus.out_ready = 1'b1;
    run_seg("seven", 7'b0000111, 7, 5, 4'h7, 1'b0);
    chk("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Reset while holding a result under backpressure
    bus.out_ready = 1'b0;
    run_seg("three", 7'b1001111, 4, 4, 4'h3, 1'b0);
    bus.seg_in = 7'b0000110;
    tick();
    chk("pre_rst_overrun", 32'(bus.overrun), 32'd1);
    rst = 1'b1;
    tick();
    chk("emit_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("emit_rst_overrun", 32'(bus.overrun), 32'd0);
    chk("emit_rst_digit", 32'(bus.digit), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    run_seg("post_rst0", 7'b0111111, 8, 0, 4'h0, 1'b0);

    // STABLE_CYCLES=1 instance: every digit decoded one edge after the change
    for (int d = 1; d <= 10; d++) begin
      bus1.seg_in = pats[d % 10];
      tick();
      chk("s1_valid", 32'(bus1.out_valid), 32'd1);
      chk("s1_digit", 32'(bus1.digit), 32'(d % 10));
      chk("s1_err", 32'(bus1.err), 32'd0);
      tick();
      chk("s1_release", 32'(bus1.out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
